// File: rtl/imul_pkg.sv
// Shared op codes and flag bit positions for the pipelined integer multiplier.
package imul_pkg;
    localparam logic [2:0] MUL_LO_U  = 3'd0;
    localparam logic [2:0] MUL_LO_S  = 3'd1;
    localparam logic [2:0] MUL_HI_U  = 3'd2;
    localparam logic [2:0] MUL_HI_S  = 3'd3;
    localparam logic [2:0] MUL_HI_SU = 3'd4;
    localparam logic [2:0] MUL_H_U   = 3'd5;
    localparam logic [2:0] MUL_H_S   = 3'd6;

    localparam int FLG_C = 5;
    localparam int FLG_O = 4;
    localparam int FLG_S = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_P = 0;
endpackage

// File: rtl/imul_flags.sv
// Result selection and {C,O,0,S,Z,P} flag generation from the 2W-bit product.
module imul_flags
    import imul_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [2*W-1:0] prod,
    input  logic [2:0]     op,
    output logic [W-1:0]   res,
    output logic [5:0]     flg
);
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;

    assign lo = prod[W-1:0];
    assign hi = prod[2*W-1:W];

    // Undefined codes fall through to the MUL_LO_U defaults.
    always_comb begin
        res = lo;
        ovf = |hi;
        case (op)
            MUL_LO_S:                      ovf = (hi != {W{lo[W-1]}});
            MUL_HI_U, MUL_HI_S, MUL_HI_SU: begin
                res = hi;
                ovf = 1'b0;
            end
            MUL_H_U:                       ovf = |lo[W-1:W/2];
            MUL_H_S:                       ovf = (lo[W-1:W/2] != {(W/2){lo[W/2-1]}});
            default: ;
        endcase

        flg        = '0;
        flg[FLG_C] = ovf;
        flg[FLG_O] = ovf;
        flg[FLG_S] = res[W-1];
        flg[FLG_Z] = ~|res;
        flg[FLG_P] = ~^res[7:0];
    end
endmodule

// File: rtl/imul_pipe.sv
// Fully pipelined W x W integer multiplier with tag tracking, stall (clkEn) and flush.
module imul_pipe
    import imul_pkg::*;
#(
    parameter int W      = 64,
    parameter int STAGES = 3,
    parameter int TAGW   = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clkEn,
    input  logic            flush,
    input  logic            in_vld,
    input  logic [2:0]      in_op,
    input  logic [TAGW-1:0] in_tag,
    input  logic [W-1:0]    A,
    input  logic [W-1:0]    B,
    output logic            out_vld,
    output logic [TAGW-1:0] out_tag,
    output logic [W-1:0]    Res,
    output logic [5:0]      flg
);
    localparam int PW = 2 * W;

    // Rank 0 = input regs, ranks 1..STAGES-1 = product, rank STAGES = output.
    logic [STAGES:0] vld_pipe;
    logic [W-1:0]    a_q, b_q;
    logic [2:0]      op_q  [STAGES];
    logic [TAGW-1:0] tag_q [STAGES];
    logic [PW-1:0]   prod_q [1:STAGES-1];

    logic            a_sgn, b_sgn, half, a_top, b_top;
    logic [PW-1:0]   a_w, b_w, prod_w;
    logic [W-1:0]    res_c, res_q;
    logic [5:0]      flg_c, flg_q;
    logic [TAGW-1:0] tag_o;

    // Extending both operands to 2W bits makes the truncated unsigned product
    // exact for every signed/unsigned mix, including min x min.
    always_comb begin
        a_sgn  = op_q[0] inside {MUL_LO_S, MUL_HI_S, MUL_HI_SU, MUL_H_S};
        b_sgn  = op_q[0] inside {MUL_LO_S, MUL_HI_S, MUL_H_S};
        half   = op_q[0] inside {MUL_H_U, MUL_H_S};
        a_top  = a_sgn & (half ? a_q[W/2-1] : a_q[W-1]);
        b_top  = b_sgn & (half ? b_q[W/2-1] : b_q[W-1]);
        a_w    = half ? {{(PW-W/2){a_top}}, a_q[W/2-1:0]} : {{(PW-W){a_top}}, a_q};
        b_w    = half ? {{(PW-W/2){b_top}}, b_q[W/2-1:0]} : {{(PW-W){b_top}}, b_q};
        prod_w = a_w * b_w;
    end

    imul_flags #(.W(W)) u_flags (
        .prod (prod_q[STAGES-1]),
        .op   (op_q[STAGES-1]),
        .res  (res_c),
        .flg  (flg_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            tag_o    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]  <= MUL_LO_U;
                tag_q[k] <= '0;
            end
            for (int k = 1; k < STAGES; k++) prod_q[k] <= '0;
        end else begin
            // Flush wins over both clkEn and a same-cycle in_vld.
            if (flush)      vld_pipe <= '0;
            else if (clkEn) vld_pipe <= {vld_pipe[STAGES-1:0], in_vld};

            if (clkEn) begin
                a_q      <= A;
                b_q      <= B;
                op_q[0]  <= in_op;
                tag_q[0] <= in_tag;
                for (int k = 1; k < STAGES; k++) begin
                    op_q[k]  <= op_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                end
                prod_q[1] <= prod_w;
                for (int k = 2; k < STAGES; k++) prod_q[k] <= prod_q[k-1];
                res_q <= res_c;
                flg_q <= flg_c;
                tag_o <= tag_q[STAGES-1];
            end
        end
    end

    assign out_vld = vld_pipe[STAGES];
    assign out_tag = tag_o;
    assign Res     = res_q;
    assign flg     = flg_q;
endmodule
